mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store engine for the 64-bit core; sits directly after the EX/MEM pipeline register and consumes its held outputs.
- Issues one data-bus transaction per load/store, holds the pipeline via a stall request until the bus acks, then aligns/extends load data and drives writeback fields to MEM/WB.
- Non-memory instructions pass through combinationally with zero added latency.

Parameters:
- LOAD_TYPE, 4'h2, inst_type code marking a load
- STORE_TYPE, 4'h3, inst_type code marking a store
- TIMEOUT, 255, max WAIT cycles before bus error; 0 disables timeout

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous active-low reset (0 = reset)
- in_rd_addr  input  6  destination reg from EX/MEM
- in_rd_w_ena  input  1  reg write enable from EX/MEM
- in_wdata  input  64  ALU result from EX/MEM
- in_mem_addr  input  64  effective byte address
- in_mem_data  input  64  store data (low bits significant)
- in_inst_type  input  4  instruction class
- in_exe_type  input  5  [1:0] size (0=B,1=H,2=W,3=D), [2] unsigned load
- stall  input  6  ctrl stall vector; bit 4 = MEM stage
- dbus_req  output  1  bus request, held until ack
- dbus_we  output  1  1 = store
- dbus_addr  output  64  in_mem_addr with [2:0] forced to 0
- dbus_wdata  output  64  store data shifted to byte lane
- dbus_wstrb  output  8  byte strobes (0 for loads)
- dbus_rdata  input  64  read data, valid with ack
- dbus_ack  input  1  one-cycle completion pulse
- stallreq_mem  output  1  stall request to ctrl
- wb_rd_addr  output  6  to MEM/WB
- wb_rd_w_ena  output  1  to MEM/WB
- wb_wdata  output  64  to MEM/WB
- bus_err  output  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst=0, async): state=IDLE, dbus_req/we=0, dbus_addr/wdata=0, wstrb=0, timeout counter=0, rdata_q=0, bus_err=0; comb outputs evaluate to 0 since stallreq/wb_rd_w_ena gated off in reset. Reset mid-transaction abandons it; no ack is awaited afterward.
- access = in_inst_type==LOAD_TYPE or STORE_TYPE.
- FSM IDLE/WAIT/DONE:
  - IDLE, !access: wb_* = in_* pass-through, stallreq_mem=0.
  - IDLE, access: stallreq_mem=1, wb_rd_w_ena=0; on clock register dbus_* and go WAIT.
  - WAIT: dbus_req=1, stallreq_mem=1, wb_rd_w_ena=0; counter increments. On dbus_ack: rdata_q<=dbus_rdata, dbus_req<=0, -> DONE. If counter reaches TIMEOUT-1 with no ack (TIMEOUT!=0): dbus_req<=0, bus_err pulses 1 in DONE, -> DONE.
  - DONE: stallreq_mem=0; load: wb_wdata = extended lane of rdata_q, wb_rd_w_ena=in_rd_w_ena; store: wb_rd_w_ena=0; bus_err case: wb_rd_w_ena=0. -> IDLE if stall[4]==NOSTOP, else hold DONE (no reissue).
- Min latency: access at cycle N, dbus_req at N+1, ack earliest N+1, DONE at N+2; stallreq_mem high for N and N+1.
- Store lanes: off=addr[2:0]; dbus_wdata = in_mem_data << (off*8); wstrb = {1,3,F,FF}[size] << off, truncated to 8 bits.
- Load: lane = rdata_q >> (off*8); sign-extend from bit 7/15/31 unless exe_type[2]=1 (zero-extend); size D ignores exe_type[2].
- ack in IDLE/DONE ignored. Counter clears entering WAIT.

Optional Feature:
- MEM_MISALIGN_EXC_EN defined: access with off not multiple of size bytes issues no bus request, goes IDLE->DONE directly, pulses bus_err, wb_rd_w_ena=0.
- Undefined: off bits below size alignment forced to 0 before lane/strobe computation; access proceeds normally.

Test Plan:
- rst=0 mid-WAIT with dbus_req=1 -> dbus_req=0, state IDLE same cycle; later ack ignored, no writeback.
- LD addr 0x1000, ack next cycle rdata 0x1122334455667788 -> dbus_addr 0x1000, wstrb 0x00, DONE wb_wdata 0x1122334455667788, stallreq high exactly 2 cycles.
- LB addr 0x2003, rdata 0x00000000_80000000 -> wb_wdata 0xFFFFFFFFFFFFFF80; LBU same -> 0x80.
- SH addr 0x3006 data 0xABCD -> dbus_wdata 0xABCD000000000000, wstrb 0xC0, dbus_we=1, wb_rd_w_ena=0.
- Load with ack after 5 wait cycles -> stallreq_mem high 6 cycles, single dbus_req burst; stall[4]=STOP in DONE holds result, no second request.
- TIMEOUT=4, no ack -> dbus_req drops after 4 WAIT cycles, bus_err one pulse, wb_rd_w_ena=0; with MEM_MISALIGN_EXC_EN, LW addr 0x4002 -> no dbus_req, bus_err pulse.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-bus port bundle between mem_access_unit (master) and the memory system (slave).
// One request is held until a single-cycle ack; rdata is valid only with ack.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic [63:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, wstrb, input rdata, ack);
  modport slave  (input req, we, addr, wdata, wstrb, output rdata, ack);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one bus transaction per load/store, stalls the pipe until ack or timeout.
// Optional macro MEM_MISALIGN_EXC_EN: misaligned accesses raise bus_err instead of being aligned down.
module mem_access_unit #(
  parameter logic [3:0]  LOAD_TYPE  = 4'h2,
  parameter logic [3:0]  STORE_TYPE = 4'h3,
  parameter int unsigned TIMEOUT    = 32'd255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               in_rd_addr,
  input  logic                     in_rd_w_ena,
  input  logic [63:0]              in_wdata,
  input  logic [63:0]              in_mem_addr,
  input  logic [63:0]              in_mem_data,
  input  logic [3:0]               in_inst_type,
  input  logic [4:0]               in_exe_type,
  input  logic [5:0]               stall,
  mem_access_unit_if.master        dbus,
  output logic                     stallreq_mem,
  output logic [5:0]               wb_rd_addr,
  output logic                     wb_rd_w_ena,
  output logic [63:0]              wb_wdata,
  output logic                     bus_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic       NOSTOP = 1'b0;

  function automatic logic [63:0] load_extend(input logic [63:0] lane, input logic [1:0] size,
                                              input logic uns);
    logic [63:0] res;
    case (size)
      2'd0:    res = {{56{~uns & lane[7]}},  lane[7:0]};
      2'd1:    res = {{48{~uns & lane[15]}}, lane[15:0]};
      2'd2:    res = {{32{~uns & lane[31]}}, lane[31:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

  logic [1:0]  state;
  logic        dbus_req_q;
  logic        dbus_we_q;
  logic [63:0] dbus_addr_q;
  logic [63:0] dbus_wdata_q;
  logic [7:0]  dbus_wstrb_q;
  logic [31:0] cnt;
  logic [63:0] rdata_q;
  logic        bus_err_q;
  logic        err_q;

  logic        access;
  logic        is_load;
  logic        is_store;
  logic [1:0]  size;
  logic [2:0]  size_mask;
  logic [2:0]  off;
  logic [7:0]  base_strb;
  logic [63:0] store_lane;
  logic [7:0]  store_strb;
  logic [63:0] load_data;
  logic        trap;
  logic        timed_out;
  logic        unused_bits;

  assign is_load     = (in_inst_type == LOAD_TYPE);
  assign is_store    = (in_inst_type == STORE_TYPE);
  assign access      = is_load | is_store;
  assign size        = in_exe_type[1:0];
  assign unused_bits = ^{stall[5], stall[3:0], in_exe_type[4:3]};

  // Size decode: alignment mask and base strobe pattern
  always_comb begin
    size_mask = 3'b000;
    base_strb = 8'h01;
    case (size)
      2'd0:    begin size_mask = 3'b000; base_strb = 8'h01; end
      2'd1:    begin size_mask = 3'b001; base_strb = 8'h03; end
      2'd2:    begin size_mask = 3'b011; base_strb = 8'h0F; end
      default: begin size_mask = 3'b111; base_strb = 8'hFF; end
    endcase
  end

  // Offset is always aligned down; in the trapping build a misaligned access never uses it
  assign off        = in_mem_addr[2:0] & ~size_mask;
  assign store_lane = in_mem_data << {off, 3'b000};
  assign store_strb = base_strb << off;
  assign load_data  = load_extend(rdata_q >> {off, 3'b000}, size, in_exe_type[2]);

`ifdef MEM_MISALIGN_EXC_EN
  assign trap = |(in_mem_addr[2:0] & size_mask);
`else
  assign trap = 1'b0;
`endif

  assign timed_out = (TIMEOUT != 32'd0) && (cnt == 32'(TIMEOUT - 32'd1));

  // Transaction FSM, bus request registers and error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= 64'd0;
      dbus_wdata_q <= 64'd0;
      dbus_wstrb_q <= 8'd0;
      cnt          <= 32'd0;
      rdata_q      <= 64'd0;
      bus_err_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (access && trap) begin
            state     <= DONE;
            err_q     <= 1'b1;
            bus_err_q <= 1'b1;
          end else if (access) begin
            state        <= WAIT;
            dbus_req_q   <= 1'b1;
            dbus_we_q    <= is_store;
            dbus_addr_q  <= {in_mem_addr[63:3], 3'b000};
            dbus_wdata_q <= is_store ? store_lane : 64'd0;
            dbus_wstrb_q <= is_store ? store_strb : 8'd0;
            cnt          <= 32'd0;
            err_q        <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          cnt <= cnt + 32'd1;
          if (dbus.ack) begin
            rdata_q    <= dbus.rdata;
            dbus_req_q <= 1'b0;
            state      <= DONE;
          end else if (timed_out) begin
            dbus_req_q <= 1'b0;
            err_q      <= 1'b1;
            bus_err_q  <= 1'b1;
            state      <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        DONE: begin
          if (stall[4] == NOSTOP) begin
            state <= IDLE;
            err_q <= 1'b0;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state      <= IDLE;
          dbus_req_q <= 1'b0;
          err_q      <= 1'b0;
        end
      endcase
    end
  end

  assign dbus.req   = dbus_req_q;
  assign dbus.we    = dbus_we_q;
  assign dbus.addr  = dbus_addr_q;
  assign dbus.wdata = dbus_wdata_q;
  assign dbus.wstrb = dbus_wstrb_q;
  assign bus_err    = bus_err_q;

  // Stall request and writeback fields; everything is forced to zero while in reset
  always_comb begin
    stallreq_mem = 1'b0;
    wb_rd_addr   = in_rd_addr;
    wb_rd_w_ena  = 1'b0;
    wb_wdata     = in_wdata;
    if (!rst) begin
      wb_rd_addr = 6'd0;
      wb_wdata   = 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            stallreq_mem = 1'b1;
          end else begin
            wb_rd_w_ena = in_rd_w_ena;
          end
        end
        WAIT: begin
          stallreq_mem = 1'b1;
        end
        DONE: begin
          if (err_q) begin
            wb_rd_w_ena = 1'b0;
          end else if (is_load) begin
            wb_rd_w_ena = in_rd_w_ena;
            wb_wdata    = load_data;
          end else begin
            wb_rd_w_ena = 1'b0;
          end
        end
        default: begin
          stallreq_mem = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-lane reference model.
// Follows MEM_MISALIGN_EXC_EN when the build defines it.
module tb_mem_access_unit;
  localparam int unsigned TMO = 8;
  localparam logic [3:0]  LD  = 4'h2;
  localparam logic [3:0]  ST  = 4'h3;
`ifdef MEM_MISALIGN_EXC_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  in_rd_addr = 6'd0;
  logic        in_rd_w_ena = 1'b0;
  logic [63:0] in_wdata = 64'd0;
  logic [63:0] in_mem_addr = 64'd0;
  logic [63:0] in_mem_data = 64'd0;
  logic [3:0]  in_inst_type = 4'd0;
  logic [4:0]  in_exe_type = 5'd0;
  logic [5:0]  stall = 6'd0;
  logic        stallreq_mem;
  logic [5:0]  wb_rd_addr;
  logic        wb_rd_w_ena;
  logic [63:0] wb_wdata;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  mem_access_unit_if dbus();

  mem_access_unit #(.LOAD_TYPE(LD), .STORE_TYPE(ST), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_rd_addr(in_rd_addr), .in_rd_w_ena(in_rd_w_ena), .in_wdata(in_wdata),
    .in_mem_addr(in_mem_addr), .in_mem_data(in_mem_data),
    .in_inst_type(in_inst_type), .in_exe_type(in_exe_type), .stall(stall),
    .dbus(dbus),
    .stallreq_mem(stallreq_mem), .wb_rd_addr(wb_rd_addr), .wb_rd_w_ena(wb_rd_w_ena),
    .wb_wdata(wb_wdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference load: pick nb bytes starting at byte off, then sign/zero extend
  function automatic logic [63:0] mdl_load(input logic [63:0] rd, input int off, input int nb,
                                           input bit uns);
    logic [63:0] v;
    logic [63:0] m;
    v = rd >> (off * 8);
    if (nb == 8) return v;
    m = (64'd1 << (nb * 8)) - 64'd1;
    v = v & m;
    if (!uns && v[nb * 8 - 1]) v = v | ~m;
    return v;
  endfunction

  task automatic do_pass();
    logic [3:0] t;
    @(negedge clk);
    t = 4'($urandom);
    if (t == LD || t == ST) t = t + 4'd4;
    in_inst_type = t;
    in_rd_addr   = 6'($urandom);
    in_rd_w_ena  = 1'($urandom);
    in_wdata     = rnd64();
    in_mem_addr  = rnd64();
    stall        = 6'($urandom);
    dbus.ack     = 1'($urandom);
    dbus.rdata   = rnd64();
    #1;
    chk("p_stallreq", 64'(stallreq_mem), 64'd0);
    chk("p_rdaddr", 64'(wb_rd_addr), 64'(in_rd_addr));
    chk("p_wben", 64'(wb_rd_w_ena), 64'(in_rd_w_ena));
    chk("p_wdata", wb_wdata, in_wdata);
    chk("p_req", 64'(dbus.req), 64'd0);
  endtask

  // One load/store from issue to retirement; ack_at >= TMO means the bus never answers
  task automatic do_mem(input bit st, input int size, input bit uns, input logic [63:0] addr,
                        input logic [63:0] data, input logic [63:0] rdat, input int ack_at,
                        input int holds);
    int nb, aoff, eoff, waits;
    bit trap, tmo;
    logic [5:0]  rd;
    logic        wen;
    logic [15:0] strb;
    nb   = 1 << size;
    aoff = int'(addr[2:0]);
    eoff = aoff - (aoff % nb);
    trap = TRAP && ((aoff % nb) != 0);
    tmo  = !trap && (ack_at >= int'(TMO));
    rd   = 6'($urandom);
    wen  = 1'($urandom);
    strb = ((16'd1 << nb) - 16'd1) << eoff;

    @(negedge clk);
    in_rd_addr   = rd;
    in_rd_w_ena  = wen;
    in_wdata     = rnd64();
    in_mem_addr  = addr;
    in_mem_data  = data;
    in_inst_type = st ? ST : LD;
    in_exe_type  = {2'($urandom), uns, 2'(size)};
    stall        = 6'($urandom) | 6'b010000;
    dbus.ack     = 1'b0;
    dbus.rdata   = rnd64();
    #1;
    chk("n_stallreq", 64'(stallreq_mem), 64'd1);
    chk("n_wben", 64'(wb_rd_w_ena), 64'd0);
    chk("n_req", 64'(dbus.req), 64'd0);

    if (!trap) begin
      waits = tmo ? int'(TMO) : ack_at + 1;
      for (int k = 0; k < waits; k++) begin
        @(negedge clk);
        dbus.ack   = (k == ack_at);
        dbus.rdata = (k == ack_at) ? rdat : rnd64();
        #1;
        chk("w_req", 64'(dbus.req), 64'd1);
        chk("w_stallreq", 64'(stallreq_mem), 64'd1);
        chk("w_wben", 64'(wb_rd_w_ena), 64'd0);
        if (k == 0) begin
          chk("w_addr", dbus.addr, addr & ~64'd7);
          chk("w_we", 64'(dbus.we), 64'(st));
          chk("w_wstrb", 64'(dbus.wstrb), st ? 64'(strb[7:0]) : 64'd0);
          if (st) chk("w_wdata", dbus.wdata, data << (eoff * 8));
        end
      end
    end

    for (int h = 0; h <= holds; h++) begin
      @(negedge clk);
      dbus.ack   = 1'($urandom);
      dbus.rdata = rnd64();
      stall      = 6'($urandom);
      stall[4]   = (h < holds);
      #1;
      chk("d_req", 64'(dbus.req), 64'd0);
      chk("d_stallreq", 64'(stallreq_mem), 64'd0);
      chk("d_buserr", 64'(bus_err), 64'((h == 0) && (trap || tmo)));
      chk("d_rdaddr", 64'(wb_rd_addr), 64'(rd));
      if (trap || tmo || st) begin
        chk("d_wben", 64'(wb_rd_w_ena), 64'd0);
      end else begin
        chk("d_wben", 64'(wb_rd_w_ena), 64'(wen));
        chk("d_wdata", wb_wdata, mdl_load(rdat, eoff, nb, uns));
      end
    end
    dbus.ack = 1'b0;
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    in_inst_type = LD;
    in_exe_type  = 5'd3;
    in_mem_addr  = 64'h5000;
    stall        = 6'b010000;
    dbus.ack     = 1'b0;
    @(negedge clk);
    #1;
    chk("r_req_pre", 64'(dbus.req), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("r_req", 64'(dbus.req), 64'd0);
    chk("r_stallreq", 64'(stallreq_mem), 64'd0);
    chk("r_wben", 64'(wb_rd_w_ena), 64'd0);
    chk("r_wdata", wb_wdata, 64'd0);
    chk("r_addr", dbus.addr, 64'd0);
    @(negedge clk);
    rst          = 1'b1;
    in_inst_type = 4'h0;
    in_rd_w_ena  = 1'b0;
    dbus.ack     = 1'b1;
    dbus.rdata   = rnd64();
    #1;
    chk("r_post_stallreq", 64'(stallreq_mem), 64'd0);
    chk("r_post_wben", 64'(wb_rd_w_ena), 64'd0);
    @(negedge clk);
    dbus.ack = 1'b0;
    #1;
    chk("r_post_req", 64'(dbus.req), 64'd0);
    chk("r_post_err", 64'(bus_err), 64'd0);
  endtask

  initial begin
    dbus.ack   = 1'b0;
    dbus.rdata = 64'd0;
    #1;
    chk("rst_req", 64'(dbus.req), 64'd0);
    chk("rst_we", 64'(dbus.we), 64'd0);
    chk("rst_addr", dbus.addr, 64'd0);
    chk("rst_wdata", dbus.wdata, 64'd0);
    chk("rst_wstrb", 64'(dbus.wstrb), 64'd0);
    chk("rst_buserr", 64'(bus_err), 64'd0);
    chk("rst_stallreq", 64'(stallreq_mem), 64'd0);
    chk("rst_wben", 64'(wb_rd_w_ena), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    do_mem(1'b0, 3, 1'b0, 64'h1000, 64'd0, 64'h1122334455667788, 0, 0);
    do_mem(1'b0, 0, 1'b0, 64'h2003, 64'd0, 64'h0000000080000000, 0, 0);
    do_mem(1'b0, 0, 1'b1, 64'h2003, 64'd0, 64'h0000000080000000, 0, 0);
    do_mem(1'b1, 1, 1'b0, 64'h3006, 64'hABCD, 64'd0, 1, 0);
    do_mem(1'b0, 2, 1'b0, 64'h2004, 64'd0, 64'h8765432100000000, 4, 3);
    do_mem(1'b0, 3, 1'b0, 64'h6008, 64'd0, 64'd0, int'(TMO), 1);
    do_mem(1'b0, 2, 1'b0, 64'h4002, 64'd0, 64'hF0E0D0C0B0A09080, 0, 1);
    do_pass();
    do_reset_mid();

    for (int i = 0; i < 60; i++) begin
      do_mem(1'($urandom), $urandom_range(0, 3), 1'($urandom), rnd64(), rnd64(), rnd64(),
             ($urandom_range(0, 9) == 0) ? int'(TMO) : $urandom_range(0, 6), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) do_pass();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
